// File: rtl/lock_seq_ctrl.sv
// Keypad door-lock sequencer: four-digit BCD code entry, code check with
// door hold timer, consecutive-failure lockout, and a two-pass code change
// flow entered by a long exit press while the door is open.
module lock_seq_ctrl #(
   parameter int unsigned UNLOCK_CYCLES  = 250000000,
   parameter int unsigned LOCKOUT_CYCLES = 500000000,
   parameter int unsigned MAX_FAIL       = 3
) (
   input  logic        clk_in,
   input  logic        rst_n,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   input  logic        confirm_pulse,
   input  logic        exit_pulse,
   input  logic        hold_exit_pulse,
   output logic        door_open,
   output logic        locked_out,
   output logic        set_mode,
   output logic [15:0] entry_value,
   output logic [2:0]  digit_cnt,
   output logic [1:0]  fail_cnt,
   output logic        pw_updated,
   output logic        entry_error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ENTRY,
      S_CHECK,
      S_OPEN,
      S_LOCKOUT,
      S_NEW_ENTRY,
      S_NEW_CONFIRM
   } state_t;

   localparam logic [30:0] UNLOCK_LAST  = 31'(UNLOCK_CYCLES - 1);
   localparam logic [30:0] LOCKOUT_LAST = 31'(LOCKOUT_CYCLES - 1);
   localparam logic [2:0]  MAX_FAIL_W   = 3'(MAX_FAIL);

   state_t      state_q;
   logic [30:0] timer_q;
   logic [15:0] stored_q;
   logic [15:0] cand_q;
   logic [15:0] entry_q;
   logic [2:0]  cnt_q;
   logic [1:0]  fail_q;
   logic        match_q;
   logic        door_q;
   logic        lock_q;
   logic        set_q;
   logic        pwu_q;
   logic        err_q;

   // Decoded input events; a full buffer swallows further digits, and a
   // confirm only counts once four digits are present.
   logic        buf_full_d;
   logic        key_ok_d;
   logic        confirm_ok_d;
   logic [15:0] entry_shift_d;
   logic [2:0]  cnt_inc_d;
   logic [2:0]  fail_inc_d;
   logic        lockout_hit_d;

   assign buf_full_d    = (cnt_q == 3'd4);
   assign key_ok_d      = key_valid && (key_code <= 4'd9) && !buf_full_d;
   assign confirm_ok_d  = confirm_pulse && buf_full_d;
   assign entry_shift_d = {entry_q[11:0], key_code};
   assign cnt_inc_d     = cnt_q + 3'd1;
   assign fail_inc_d    = {1'b0, fail_q} + 3'd1;
   assign lockout_hit_d = (fail_inc_d >= MAX_FAIL_W);

   // Sequencer FSM; all outputs are registered and pulses self-clear.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         timer_q  <= '0;
         stored_q <= 16'h0000;
         cand_q   <= '0;
         entry_q  <= '0;
         cnt_q    <= '0;
         fail_q   <= '0;
         match_q  <= 1'b0;
         door_q   <= 1'b0;
         lock_q   <= 1'b0;
         set_q    <= 1'b0;
         pwu_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         pwu_q <= 1'b0;
         err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // Buffer is always empty here, so any valid digit starts entry.
               if (key_ok_d) begin
                  entry_q <= entry_shift_d;
                  cnt_q   <= cnt_inc_d;
                  timer_q <= '0;
                  state_q <= S_ENTRY;
               end
            end
            S_ENTRY: begin
               if (exit_pulse) begin
                  entry_q <= '0;
                  cnt_q   <= '0;
                  timer_q <= '0;
                  state_q <= S_IDLE;
               end else if (confirm_ok_d) begin
                  // Compare now so the buffer can be cleared on leaving ENTRY.
                  match_q <= (entry_q == stored_q);
                  entry_q <= '0;
                  cnt_q   <= '0;
                  timer_q <= '0;
                  state_q <= S_CHECK;
               end else if (key_ok_d) begin
                  entry_q <= entry_shift_d;
                  cnt_q   <= cnt_inc_d;
               end
            end
            S_CHECK: begin
               timer_q <= '0;
               if (match_q) begin
                  fail_q  <= '0;
                  door_q  <= 1'b1;
                  state_q <= S_OPEN;
               end else begin
                  err_q  <= 1'b1;
                  fail_q <= fail_inc_d[1:0];
                  if (lockout_hit_d) begin
                     lock_q  <= 1'b1;
                     state_q <= S_LOCKOUT;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            S_OPEN: begin
               if (hold_exit_pulse) begin
                  door_q  <= 1'b0;
                  set_q   <= 1'b1;
                  timer_q <= '0;
                  state_q <= S_NEW_ENTRY;
               end else if (timer_q == UNLOCK_LAST) begin
                  door_q  <= 1'b0;
                  timer_q <= '0;
                  state_q <= S_IDLE;
               end else begin
                  timer_q <= timer_q + 31'd1;
               end
            end
            S_LOCKOUT: begin
               if (timer_q == LOCKOUT_LAST) begin
                  lock_q  <= 1'b0;
                  fail_q  <= '0;
                  timer_q <= '0;
                  state_q <= S_IDLE;
               end else begin
                  timer_q <= timer_q + 31'd1;
               end
            end
            S_NEW_ENTRY: begin
               if (exit_pulse) begin
                  entry_q <= '0;
                  cnt_q   <= '0;
                  set_q   <= 1'b0;
                  timer_q <= '0;
                  state_q <= S_IDLE;
               end else if (confirm_ok_d) begin
                  cand_q  <= entry_q;
                  entry_q <= '0;
                  cnt_q   <= '0;
                  timer_q <= '0;
                  state_q <= S_NEW_CONFIRM;
               end else if (key_ok_d) begin
                  entry_q <= entry_shift_d;
                  cnt_q   <= cnt_inc_d;
               end
            end
            S_NEW_CONFIRM: begin
               if (exit_pulse) begin
                  entry_q <= '0;
                  cnt_q   <= '0;
                  set_q   <= 1'b0;
                  timer_q <= '0;
                  state_q <= S_IDLE;
               end else if (confirm_ok_d) begin
                  // Only a repeated identical code replaces the stored one.
                  if (entry_q == cand_q) begin
                     stored_q <= cand_q;
                     pwu_q    <= 1'b1;
                  end else begin
                     err_q <= 1'b1;
                  end
                  entry_q <= '0;
                  cnt_q   <= '0;
                  set_q   <= 1'b0;
                  timer_q <= '0;
                  state_q <= S_IDLE;
               end else if (key_ok_d) begin
                  entry_q <= entry_shift_d;
                  cnt_q   <= cnt_inc_d;
               end
            end
            default: begin
               entry_q <= '0;
               cnt_q   <= '0;
               door_q  <= 1'b0;
               lock_q  <= 1'b0;
               set_q   <= 1'b0;
               timer_q <= '0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign door_open   = door_q;
   assign locked_out  = lock_q;
   assign set_mode    = set_q;
   assign entry_value = entry_q;
   assign digit_cnt   = cnt_q;
   assign fail_cnt    = fail_q;
   assign pw_updated  = pwu_q;
   assign entry_error = err_q;

endmodule

// File: tb/tb_lock_seq_ctrl.sv
// Self-checking bench for lock_seq_ctrl: directed scenarios followed by a
// randomized session, compared against a transaction-level model of the
// lock (stored code, failure count, digit list).
module tb_lock_seq_ctrl;

   localparam int U    = 5;
   localparam int L    = 7;
   localparam int MAXF = 3;

   logic        clk_in = 1'b0;
   logic        rst_n = 1'b0;
   logic        key_valid = 1'b0;
   logic [3:0]  key_code = 4'd0;
   logic        confirm_pulse = 1'b0;
   logic        exit_pulse = 1'b0;
   logic        hold_exit_pulse = 1'b0;
   logic        door_open;
   logic        locked_out;
   logic        set_mode;
   logic [15:0] entry_value;
   logic [2:0]  digit_cnt;
   logic [1:0]  fail_cnt;
   logic        pw_updated;
   logic        entry_error;

   lock_seq_ctrl #(
      .UNLOCK_CYCLES (U),
      .LOCKOUT_CYCLES(L),
      .MAX_FAIL      (MAXF)
   ) dut (
      .clk_in         (clk_in),
      .rst_n          (rst_n),
      .key_valid      (key_valid),
      .key_code       (key_code),
      .confirm_pulse  (confirm_pulse),
      .exit_pulse     (exit_pulse),
      .hold_exit_pulse(hold_exit_pulse),
      .door_open      (door_open),
      .locked_out     (locked_out),
      .set_mode       (set_mode),
      .entry_value    (entry_value),
      .digit_cnt      (digit_cnt),
      .fail_cnt       (fail_cnt),
      .pw_updated     (pw_updated),
      .entry_error    (entry_error)
   );

   always #5 clk_in = ~clk_in;

   int n_pass = 0;
   int n_total = 0;

   // Model of the lock: stored code, consecutive failures, digits typed.
   int m_code = 0;
   int m_fail = 0;
   int m_cand = 0;
   int m_digits[$];

   function automatic int buf_val();
      int v = 0;
      foreach (m_digits[i]) v = v * 16 + m_digits[i];
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic key(input int d);
      key_valid = 1'b1;
      key_code  = 4'(d);
      tick();
      key_valid = 1'b0;
      if (d < 10 && m_digits.size() < 4) m_digits.push_back(d);
      chk("digit_cnt", 32'(digit_cnt), m_digits.size());
      chk("entry_value", 32'(entry_value), buf_val());
   endtask

   task automatic enter_code(input int v);
      for (int i = 3; i >= 0; i--) key((v >> (4 * i)) & 15);
   endtask

   // Confirm a full buffer and follow the result: door window, hold-exit
   // into code change, plain failure, or full lockout.
   task automatic confirm_eval(input bit hold);
      bit exp_open;
      confirm_pulse = 1'b1;
      tick();
      confirm_pulse = 1'b0;
      exp_open = (buf_val() == m_code);
      m_digits.delete();
      chk("cnt_after_confirm", 32'(digit_cnt), 0);
      chk("door_during_check", 32'(door_open), 0);
      tick();
      if (exp_open) begin
         m_fail = 0;
         chk("door_rise", 32'(door_open), 1);
         chk("err_on_match", 32'(entry_error), 0);
         chk("fail_on_match", 32'(fail_cnt), 0);
         if (hold) begin
            hold_exit_pulse = 1'b1;
            tick();
            hold_exit_pulse = 1'b0;
            chk("door_after_hold", 32'(door_open), 0);
            chk("set_mode_after_hold", 32'(set_mode), 1);
         end else begin
            for (int i = 1; i < U; i++) begin
               tick();
               chk("door_hold", 32'(door_open), 1);
            end
            tick();
            chk("door_close", 32'(door_open), 0);
         end
      end else begin
         m_fail++;
         chk("err_on_mismatch", 32'(entry_error), 1);
         chk("door_on_mismatch", 32'(door_open), 0);
         chk("fail_cnt", 32'(fail_cnt), m_fail);
         if (m_fail >= MAXF) begin
            chk("locked_rise", 32'(locked_out), 1);
            for (int i = 1; i < L; i++) begin
               key_valid     = 1'b1;
               key_code      = 4'($urandom_range(0, 9));
               confirm_pulse = 1'b1;
               exit_pulse    = 1'($urandom_range(0, 1));
               tick();
               chk("locked_hold", 32'(locked_out), 1);
               chk("cnt_in_lockout", 32'(digit_cnt), 0);
            end
            key_valid     = 1'b0;
            confirm_pulse = 1'b0;
            exit_pulse    = 1'b0;
            tick();
            m_fail = 0;
            chk("locked_end", 32'(locked_out), 0);
            chk("fail_after_lockout", 32'(fail_cnt), 0);
         end else begin
            chk("locked_low", 32'(locked_out), 0);
            tick();
            chk("err_pulse_end", 32'(entry_error), 0);
         end
      end
   endtask

   // Two-pass code change starting in NEW_ENTRY.
   task automatic change_code(input int a, input int b);
      bit exp_pw;
      enter_code(a);
      confirm_pulse = 1'b1;
      tick();
      confirm_pulse = 1'b0;
      m_cand = buf_val();
      m_digits.delete();
      chk("cnt_new_confirm", 32'(digit_cnt), 0);
      chk("set_mode_new_confirm", 32'(set_mode), 1);
      enter_code(b);
      confirm_pulse = 1'b1;
      tick();
      confirm_pulse = 1'b0;
      exp_pw = (buf_val() == m_cand);
      if (exp_pw) m_code = m_cand;
      m_digits.delete();
      chk("pw_updated", 32'(pw_updated), 32'(exp_pw));
      chk("err_change", 32'(entry_error), 32'(!exp_pw));
      chk("set_mode_done", 32'(set_mode), 0);
      chk("fail_change", 32'(fail_cnt), m_fail);
      tick();
      chk("pw_pulse_end", 32'(pw_updated), 0);
      chk("err_pulse_end2", 32'(entry_error), 0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_door"}, 32'(door_open), 0);
      chk({tag, "_locked"}, 32'(locked_out), 0);
      chk({tag, "_set"}, 32'(set_mode), 0);
      chk({tag, "_entry"}, 32'(entry_value), 0);
      chk({tag, "_cnt"}, 32'(digit_cnt), 0);
      chk({tag, "_fail"}, 32'(fail_cnt), 0);
      chk({tag, "_pw"}, 32'(pw_updated), 0);
      chk({tag, "_err"}, 32'(entry_error), 0);
   endtask

   function automatic int rand_code();
      int v = 0;
      for (int i = 0; i < 4; i++) v = v * 16 + int'($urandom_range(0, 9));
      return v;
   endfunction

   initial begin
      // Reset state
      repeat (3) @(posedge clk_in);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();
      check_all_zero("post_reset");

      // Default code opens the door for the hold window
      enter_code(16'h0000);
      confirm_eval(1'b0);

      // Three wrong codes lead to lockout, inputs ignored meanwhile
      for (int i = 0; i < 3; i++) begin
         enter_code(16'h1234);
         confirm_eval(1'b0);
      end

      // Ignored inputs: early confirm, codes 10-15, a fifth digit
      key(3);
      confirm_pulse = 1'b1;
      tick();
      confirm_pulse = 1'b0;
      chk("early_confirm_ignored", 32'(digit_cnt), m_digits.size());
      key(11);
      key(1);
      key(4);
      key(1);
      key(9);
      key(15);
      confirm_eval(1'b0);
      enter_code(16'h0000);
      confirm_eval(1'b0);

      // Code change to 5678, old code then fails, new code opens
      enter_code(16'h0000);
      confirm_eval(1'b1);
      change_code(16'h5678, 16'h5678);
      enter_code(16'h0000);
      confirm_eval(1'b0);
      enter_code(16'h5678);
      confirm_eval(1'b0);

      // Reset in the middle of the door window
      enter_code(16'h5678);
      confirm_pulse = 1'b1;
      tick();
      confirm_pulse = 1'b0;
      m_digits.delete();
      tick();
      tick();
      chk("door_before_reset", 32'(door_open), 1);
      rst_n = 1'b0;
      #1;
      chk("door_async_reset", 32'(door_open), 0);
      m_code = 0;
      m_fail = 0;
      tick();
      check_all_zero("mid_open_reset");
      rst_n = 1'b1;
      tick();

      // Mismatched change keeps the restored 0000 code
      enter_code(16'h0000);
      confirm_eval(1'b1);
      change_code(16'h5678, 16'h5679);
      enter_code(16'h0000);
      confirm_eval(1'b0);

      // Exit beats confirm in the same cycle: no check, no failure counted
      enter_code(16'h1111);
      confirm_eval(1'b0);
      enter_code(m_code);
      exit_pulse    = 1'b1;
      confirm_pulse = 1'b1;
      tick();
      exit_pulse    = 1'b0;
      confirm_pulse = 1'b0;
      m_digits.delete();
      chk("exit_cnt", 32'(digit_cnt), 0);
      tick();
      chk("exit_no_door", 32'(door_open), 0);
      chk("exit_no_err", 32'(entry_error), 0);
      chk("exit_fail_kept", 32'(fail_cnt), m_fail);
      tick();
      chk("exit_no_door_late", 32'(door_open), 0);

      // Randomized session
      for (int it = 0; it < 30; it++) begin
         int sel = int'($urandom_range(0, 9));
         if (sel < 2) begin
            int nd = int'($urandom_range(1, 3));
            for (int k = 0; k < nd; k++) key(int'($urandom_range(0, 15)));
            exit_pulse = 1'b1;
            tick();
            exit_pulse = 1'b0;
            m_digits.delete();
            chk("rand_exit_cnt", 32'(digit_cnt), 0);
            chk("rand_exit_fail", 32'(fail_cnt), m_fail);
         end else begin
            int code = ($urandom_range(0, 1) != 0) ? m_code : rand_code();
            bit hold = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) != 0) key(int'($urandom_range(10, 15)));
            enter_code(code);
            if ($urandom_range(0, 2) == 0) key(int'($urandom_range(0, 15)));
            confirm_eval(hold);
            if (hold && code == m_code) begin
               int a = rand_code();
               int b = ($urandom_range(0, 1) != 0) ? a : rand_code();
               change_code(a, b);
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
